// File: rtl/cursor_position_ctrl_pkg.sv
// Shared types and constants for the 4x4 cursor controller feeding the 4-to-16 position decoder.
// Also holds the wrap-around move helper used by the top level.
package cursor_position_ctrl_pkg;

  localparam int GRID_DIM  = 4;
  localparam int POS_W     = 4;
  localparam int NUM_CELLS = 16;

  // Bit positions inside the packed button vector {sel, up, down, left, right}.
  localparam int BTN_W     = 5;
  localparam int BTN_SEL   = 4;
  localparam int BTN_UP    = 3;
  localparam int BTN_DOWN  = 2;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    REJECT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  // Row and column are 2-bit fields, so plain +/-1 wraps modulo 4 without touching the other field.
  function automatic logic [POS_W-1:0] step_pos(input logic [POS_W-1:0] pos,
                                                input logic [BTN_W-1:0] rise);
    logic [1:0] row;
    logic [1:0] col;
    row = pos[3:2];
    col = pos[1:0];
    if (rise[BTN_UP])         row = row - 2'd1;
    else if (rise[BTN_DOWN])  row = row + 2'd1;
    else if (rise[BTN_LEFT])  col = col - 2'd1;
    else if (rise[BTN_RIGHT]) col = col + 2'd1;
    return {row, col};
  endfunction

endpackage

// File: rtl/cursor_position_ctrl_if.sv
// Button/occupancy inputs and cursor/strobe outputs of the cursor controller.
// Handshake: none; pos_en and reject are single-cycle strobes, valid only while busy is high.
interface cursor_position_ctrl_if;
  import cursor_position_ctrl_pkg::*;

  logic                 btn_up;
  logic                 btn_down;
  logic                 btn_left;
  logic                 btn_right;
  logic                 btn_sel;
  logic [NUM_CELLS-1:0] occupied;
  logic [POS_W-1:0]     pos;
  logic                 pos_en;
  logic                 reject;
  logic                 busy;
  state_t               state;

  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_sel, occupied,
    input  pos, pos_en, reject, busy, state
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_sel, occupied,
    output pos, pos_en, reject, busy, state
  );

endinterface

// File: rtl/cursor_position_ctrl_btn_edge_detect.sv
// Per-bit rising-edge detector; history resets to 1 so a level held through reset is not an edge.
module cursor_position_ctrl_btn_edge_detect #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] level,
  output logic [W-1:0] rise
);

  logic [W-1:0] hist_q;
  logic [W-1:0] hist_d;

  always_comb begin
    hist_d = level;
    rise   = level & ~hist_q;
  end

  always_ff @(posedge clk) begin
    if (rst) hist_q <= '1;
    else     hist_q <= hist_d;
  end

endmodule

// File: rtl/cursor_position_ctrl.sv
// Cursor position controller: moves a 4x4 cursor from button edges and issues commit/reject
// strobes followed by a lockout window during which all button edges are dropped.
module cursor_position_ctrl
  import cursor_position_ctrl_pkg::*;
#(
  parameter int INIT_POS       = 0,
  parameter int LOCKOUT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  cursor_position_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(LOCKOUT_CYCLES) + 1;

  logic [BTN_W-1:0] btn_level;
  logic [BTN_W-1:0] btn_rise;

  state_t           state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign btn_level = {bus.btn_sel, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};

  cursor_position_ctrl_btn_edge_detect #(.W(BTN_W)) u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (btn_level),
    .rise  (btn_rise)
  );

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // occupied is sampled in the same cycle as the sel edge; sel wins over any move.
        if (btn_rise[BTN_SEL]) state_d = bus.occupied[pos_q] ? REJECT : COMMIT;
        else                   pos_d   = step_pos(pos_q, btn_rise);
      end
      COMMIT, REJECT: begin
        state_d = LOCK;
        cnt_d   = CNT_W'(LOCKOUT_CYCLES - 1);
      end
      LOCK: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= POS_W'(INIT_POS);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from the registered state, so they are glitch-free for the decoder.
  assign bus.pos    = pos_q;
  assign bus.pos_en = (state_q == COMMIT);
  assign bus.reject = (state_q == REJECT);
  assign bus.busy   = (state_q != IDLE);
  assign bus.state  = state_q;

endmodule
